ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM (16-bit address, 32-bit word) between two requesters: port 0 (processor load/store unit) and port 1 (button/switch-driven debug viewer and loader).
- Sits between the requesters and the RAM macro. Issues at most one access per cycle, returns read data in order with a fixed latency, and tags each read return to the port that issued it.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, data word width.
- RD_LAT, 2, RAM read latency in cycles, from RAM inputs valid to ram_q valid (1..4).
- MAX_BURST, 4, maximum consecutive port-0 grants in fixed-priority mode while port 1 is waiting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- switch  in  1  arbitration mode: 1 = fixed priority to port 0 with starvation guard; 0 = round robin.
- p0_req  in  1  port 0 request (valid).
- p0_we  in  1  port 0 write enable (1 = write, 0 = read).
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 grant (ready, combinational).
- p0_rvalid  out  1  port 0 read data valid, one-cycle pulse.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- ram_address  out  ADDR_W  RAM address (registered).
- ram_data  out  DATA_W  RAM write data (registered).
- ram_wren  out  1  RAM write enable (registered).
- ram_q  in  DATA_W  RAM read data.
- busy  out  1  high while any req is high or any read is in flight.

Behaviour:
- Handshake:
  - req/gnt is valid/ready. A transfer occurs at the rising edge ending a cycle where req and gnt are both high.
  - The requester holds we/addr/wdata stable while req is high and gnt is low.
  - gnt depends combinationally on req, switch and internal state, never on addr, we or wdata.
  - At most one gnt is high per cycle.
  - Back-to-back transfers from the same port are allowed.
- Issue: a transfer in cycle t drives ram_address/ram_data/ram_wren in cycle t+1. With no transfer in cycle t, ram_wren = 0 in t+1 and ram_address/ram_data hold their last values.
- Read return:
  - A read transferred in cycle t raises pN_rvalid in exactly cycle t+1+RD_LAT, with pN_rdata = ram_q in that cycle.
  - Implement as a RD_LAT+1 deep shift register of {valid, port}.
  - Both rdata outputs carry ram_q at all times; only rvalid qualifies them.
  - Returns come back in issue order. Writes produce no rvalid.
- Arbitration state:
  - last (port of most recent grant, reset 1 so port 0 wins first in round robin).
  - burst counter (0..MAX_BURST, reset 0).
- Round robin (switch=0): if only one req is high, grant it. If both are high, grant the port != last.
- Fixed priority (switch=1):
  - p0 is granted whenever p0_req is high, except when p1_req is high and burst == MAX_BURST; then p1 is granted.
  - burst increments on a p0 grant while p1_req is high, saturating at MAX_BURST.
  - burst clears on any p1 grant, or on a p0 grant while p1_req is low.
- Mode change: switch may toggle any cycle. The new mode applies in the same cycle. last and burst are not cleared.
- Idle cycles (no req): last and burst hold.
- busy = p0_req | p1_req | any valid bit in the return pipeline.
- Reset (rst=0 at a clock edge), including mid-operation:
  - All return-pipeline valid bits clear, so in-flight reads are dropped and never raise rvalid.
  - ram_wren=0, ram_address=0, ram_data=0, last=1, burst=0.
  - While rst is low: both gnt=0, both rvalid=0, busy=0.
  - A write issued in the cycle before reset still reaches the RAM, since ram_wren was already registered.
- Address wrap: no arithmetic on addresses; 0xFFFF passes through unchanged.

Test Plan:
- Single read: RAM preloaded with mem[0x0010]=0xDEADBEEF; p0 read 0x0010 at cycle 5 -> p0_gnt=1 in cycle 5; ram_address=0x0010, ram_wren=0 in cycle 6; p0_rvalid=1 with p0_rdata=0xDEADBEEF in cycle 8 (RD_LAT=2); p1_rvalid stays 0.
- Write then read, same address: p1 writes 0x12345678 to 0xFFFF, next cycle p1 reads 0xFFFF -> ram_wren=1 for exactly one cycle; p1_rvalid one time, with p1_rdata=0x12345678.
- Round robin (switch=0): both ports hold read req for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1; rvalid pulses alternate ports in the same order, each 3 cycles after its grant.
- Fixed priority with guard (switch=1, MAX_BURST=4): both req continuous -> pattern p0,p0,p0,p0,p1 repeating; with p1_req low, p0 granted every cycle and burst stays 0.
- Reset mid-operation: p0 reads issued in cycles 10 and 11, rst=0 in cycle 12 -> no rvalid in cycles 13–14; gnt=0, ram_wren=0, busy=0 while rst low; after release with both requesting, round robin grants p0 first.
- Mode toggle: switch 1->0 while both request and last=0 -> p1 granted the same cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port data RAM.
// Round robin or fixed priority with starvation guard; in-order tagged read returns.
module ram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  localparam int BW = $clog2(MAX_BURST + 1);

  logic              last;
  logic [BW-1:0]     burst;
  logic              burst_max;
  logic [RD_LAT:0]   pv;
  logic [RD_LAT:0]   pp;
  logic              g0;
  logic              g1;
  logic              xfer;
  logic              xwe;
  logic [ADDR_W-1:0] xaddr;
  logic [DATA_W-1:0] xdata;

  assign burst_max = (burst == BW'(MAX_BURST));

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      if (switch) begin
        g1 = p1_req & (~p0_req | burst_max);
        g0 = p0_req & ~g1;
      end else begin
        g0 = p0_req & (~p1_req | last);
        g1 = p1_req & ~g0;
      end
    end
  end

  always_comb begin
    xfer  = g0 | g1;
    xwe   = p0_we;
    xaddr = p0_addr;
    xdata = p0_wdata;
    unique case (1'b1)
      g1: begin
        xwe   = p1_we;
        xaddr = p1_addr;
        xdata = p1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      last        <= 1'b1;
      burst       <= '0;
      pv          <= '0;
      pp          <= '0;
    end else begin
      ram_wren <= xfer & xwe;
      if (xfer) begin
        ram_address <= xaddr;
        ram_data    <= xdata;
        last        <= g1;
      end
      // starvation guard only counts in fixed-priority mode
      if (switch) begin
        if (g0 & p1_req) begin
          if (!burst_max) burst <= burst + 1'b1;
        end else if (xfer) begin
          burst <= '0;
        end
      end
      pv <= {pv[RD_LAT-1:0], xfer & ~xwe};
      pp <= {pp[RD_LAT-1:0], g1};
    end
  end

  assign p0_gnt    = g0;
  assign p1_gnt    = g1;
  assign p0_rvalid = rst & pv[RD_LAT] & ~pp[RD_LAT];
  assign p1_rvalid = rst & pv[RD_LAT] & pp[RD_LAT];
  assign p0_rdata  = ram_q;
  assign p1_rdata  = ram_q;
  assign busy      = rst & (p0_req | p1_req | (|pv));

endmodule
